// File: rtl/ext_bus_initiator_if.sv
// EXT bus initiator interface: command, response and EXT bus signals.
// master = initiator side, slave = command source / bus responder side.
interface ext_bus_initiator_if #(
   parameter int AWIDTH = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AWIDTH-1:0] cmd_addr;
   logic [3:0]        cmd_len;
   logic [31:0]       cmd_wdata;
   logic [3:0]        cmd_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              ext_en;
   logic [3:0]        ext_wea;
   logic [AWIDTH-1:0] ext_addr;
   logic [31:0]       ext_din;
   logic [31:0]       ext_dout;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr,
      input  cmd_len, cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_rdata,
      input  rsp_ready,
      output ext_en, ext_wea, ext_addr, ext_din,
      input  ext_dout
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr,
      output cmd_len, cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata,
      output rsp_ready,
      input  ext_en, ext_wea, ext_addr, ext_din,
      output ext_dout
   );
endinterface

// File: rtl/ext_bus_initiator.sv
// EXT bus initiator: single/burst read/write commands, read data via FIFO.
// Ports: cpu_clk_g, reset_button (async, active-high), bus (master), busy.
// Optional: EXT_BUS_INITIATOR_WRACK_EN pushes one response per write.
module ext_bus_initiator #(
   parameter int AWIDTH    = 16,
   parameter int RSP_DEPTH = 4
) (
   input  logic                cpu_clk_g,
   input  logic                reset_button,
   ext_bus_initiator_if.master bus,
   output logic                busy
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = PW + 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;

   logic [1:0]        r_state;
   logic [4:0]        r_rem;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wstrb;
   logic [AWIDTH-1:0] r_nxt;
   logic              r_en;
   logic              r_rd;
   logic              r_cap;
   logic [3:0]        r_wea;
   logic [AWIDTH-1:0] r_addr;
   logic [31:0]       r_din;
   logic [31:0]       r_mem [RSP_DEPTH];
   logic [PW-1:0]     r_wp;
   logic [PW-1:0]     r_rp;
   logic [PW:0]       r_cnt;
`ifdef EXT_BUS_INITIATOR_WRACK_EN
   logic [3:0]        r_len;
`endif

   logic              w_issue;
   logic              w_write;
   logic              w_room;
   logic              w_wr_room;
   logic              w_started;
   logic              w_wack;
   logic              w_push;
   logic              w_pop;
   logic [AWIDTH-1:0] w_iaddr;
   logic [3:0]        w_iwea;
   logic [31:0]       w_idin;
   logic [31:0]       w_pdata;

   // Reads in flight (beat on bus + capture pending) hold a FIFO slot.
   assign w_room = ({1'b0, r_cnt} + CW'(r_rd) + CW'(r_cap))
                   < CW'(RSP_DEPTH);

`ifdef EXT_BUS_INITIATOR_WRACK_EN
   // The ack slot is reserved before the first write beat.
   assign w_started = (r_rem != ({1'b0, r_len} + 5'd1));
   assign w_wr_room = w_room;
   assign w_wack    = (r_state == S_WR) && (r_rem == 5'd0);
   assign w_pdata   = r_cap ? bus.ext_dout : {28'd0, r_len};
`else
   assign w_started = 1'b1;
   assign w_wr_room = 1'b1;
   assign w_wack    = 1'b0;
   assign w_pdata   = bus.ext_dout;
`endif

   assign w_push = r_cap | w_wack;
   assign w_pop  = (r_cnt != '0) & bus.rsp_ready;

   // First beat issues straight from the command so it lands next cycle.
   always_comb begin
      w_issue = 1'b0;
      w_write = 1'b0;
      w_iaddr = r_nxt;
      w_iwea  = r_wstrb;
      w_idin  = r_wdata;
      unique case (r_state)
         S_IDLE: begin
            w_write = bus.cmd_write;
            w_iaddr = bus.cmd_addr;
            w_iwea  = bus.cmd_wstrb;
            w_idin  = bus.cmd_wdata;
            w_issue = bus.cmd_valid &
                      (bus.cmd_write ? w_wr_room : w_room);
         end
         S_WR: begin
            w_write = 1'b1;
            w_issue = (r_rem != 5'd0) & (w_started | w_wr_room);
         end
         S_RD: begin
            w_issue = (r_rem != 5'd0) & w_room;
         end
         default: begin
            w_issue = 1'b0;
         end
      endcase
   end

   always_ff @(posedge cpu_clk_g or posedge reset_button) begin
      if (reset_button) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_nxt   <= '0;
         r_en    <= 1'b0;
         r_rd    <= 1'b0;
         r_cap   <= 1'b0;
         r_wea   <= '0;
         r_addr  <= '0;
         r_din   <= '0;
`ifdef EXT_BUS_INITIATOR_WRACK_EN
         r_len   <= '0;
`endif
      end else begin
         r_en  <= w_issue;
         r_rd  <= w_issue & ~w_write;
         r_cap <= r_rd;
         r_wea <= (w_issue & w_write) ? w_iwea : 4'd0;
         if (w_issue) begin
            r_addr <= w_iaddr;
            r_nxt  <= w_iaddr + AWIDTH'(1);
            if (w_write)
               r_din <= w_idin;
         end else if (r_state == S_IDLE && bus.cmd_valid) begin
            r_nxt <= bus.cmd_addr;
         end
         unique case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_wdata <= bus.cmd_wdata;
                  r_wstrb <= bus.cmd_wstrb;
                  r_rem   <= {1'b0, bus.cmd_len} + 5'd1
                             - {4'd0, w_issue};
`ifdef EXT_BUS_INITIATOR_WRACK_EN
                  r_len   <= bus.cmd_len;
`endif
                  r_state <= bus.cmd_write ? S_WR : S_RD;
               end
            end
            S_WR, S_RD: begin
               if (r_rem == 5'd0)
                  r_state <= S_IDLE;
               else if (w_issue)
                  r_rem <= r_rem - 5'd1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge cpu_clk_g or posedge reset_button) begin
      if (reset_button) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push)
            r_wp <= r_wp + PW'(1);
         if (w_pop)
            r_rp <= r_rp + PW'(1);
         r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   always_ff @(posedge cpu_clk_g) begin
      if (w_push)
         r_mem[r_wp] <= w_pdata;
   end

   assign bus.cmd_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_cnt != '0);
   assign bus.rsp_rdata = bus.rsp_valid ? r_mem[r_rp] : 32'd0;
   assign bus.ext_en    = r_en;
   assign bus.ext_wea   = r_wea;
   assign bus.ext_addr  = r_addr;
   assign bus.ext_din   = r_din;
   assign busy          = (r_state != S_IDLE) | r_rd | r_cap;
endmodule

// File: tb/tb_ext_bus_initiator.sv
// Testbench for ext_bus_initiator: vector table, corner sequences, random.
// Reference model: per-command expected beat and response queues.
module tb_ext_bus_initiator;
   bit   cpu_clk_g = 1'b0;
   logic reset_button;
   logic busy;
   int   rdy_mode = 1;

   ext_bus_initiator_if #(.AWIDTH(16)) bus ();

   ext_bus_initiator #(.AWIDTH(16), .RSP_DEPTH(4)) dut (
      .cpu_clk_g    (cpu_clk_g),
      .reset_button (reset_button),
      .bus          (bus),
      .busy         (busy)
   );

   always #5 cpu_clk_g = ~cpu_clk_g;

   typedef struct {
      logic [15:0] a;
      logic [3:0]  s;
      logic [31:0] d;
   } beat_t;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [3:0]  len;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [15:0] exp_last_addr;
      logic [31:0] exp_last_rsp;
   } vec_t;

   beat_t       exp_beat[$];
   logic [31:0] exp_rsp[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          beat_cnt = 0;
   int          rd_issued = 0;
   int          pops = 0;
   logic [15:0] last_addr = '0;
   logic [31:0] last_rsp = '0;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endfunction

   // Slave: registered read data, addr ^ 0x5A5A.
   always @(posedge cpu_clk_g)
      if (bus.ext_en && bus.ext_wea == 4'd0)
         bus.ext_dout <= 32'(bus.ext_addr ^ 16'h5A5A);

   always @(posedge cpu_clk_g) begin
      #1;
      if (rdy_mode == 2)
         bus.rsp_ready = 1'($urandom_range(0, 1));
      else
         bus.rsp_ready = (rdy_mode == 1);
   end

   always @(negedge cpu_clk_g) begin
      if (!reset_button) begin
         if (bus.ext_en) begin
            beat_cnt++;
            last_addr = bus.ext_addr;
            if (exp_beat.size() == 0) begin
               chk("unexpected_beat", 32'(bus.ext_addr), 32'hFFFF_FFFF);
            end else begin
               beat_t e;
               e = exp_beat.pop_front();
               chk("beat_addr", 32'(bus.ext_addr), 32'(e.a));
               chk("beat_wea", 32'(bus.ext_wea), 32'(e.s));
               if (e.s != 4'd0)
                  chk("beat_din", bus.ext_din, e.d);
            end
            if (bus.ext_wea == 4'd0) begin
               rd_issued++;
               if (rd_issued - pops > 4)
                  chk("rd_overcommit", 32'(rd_issued - pops), 32'd4);
            end
         end else if (bus.ext_wea != 4'd0) begin
            chk("idle_wea", 32'(bus.ext_wea), 32'd0);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            pops++;
            last_rsp = bus.rsp_rdata;
            if (exp_rsp.size() == 0)
               chk("unexpected_rsp", bus.rsp_rdata, 32'hDEAD_0000);
            else
               chk("rsp_data", bus.rsp_rdata, exp_rsp.pop_front());
         end
      end
   end

   task automatic issue(input bit wr, input logic [15:0] a,
                        input logic [3:0] l, input logic [31:0] d,
                        input logic [3:0] s);
      int n = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      bus.cmd_wdata = d;
      bus.cmd_wstrb = s;
      do begin
         @(negedge cpu_clk_g);
         n++;
      end while (!bus.cmd_ready && n < 300);
      if (!bus.cmd_ready) begin
         chk("accept_timeout", 32'(n), 32'd0);
         bus.cmd_valid = 1'b0;
      end else begin
         @(posedge cpu_clk_g);
         for (int i = 0; i <= int'(l); i++) begin
            beat_t b;
            b.a = a + 16'(i);
            b.s = wr ? s : 4'd0;
            b.d = d;
            exp_beat.push_back(b);
            if (!wr)
               exp_rsp.push_back(32'(b.a ^ 16'h5A5A));
         end
`ifdef EXT_BUS_INITIATOR_WRACK_EN
         if (wr)
            exp_rsp.push_back(32'(l));
`endif
         #1 bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge cpu_clk_g);
         n++;
      end while (!(busy == 1'b0 && bus.cmd_ready &&
                   exp_beat.size() == 0 && exp_rsp.size() == 0)
                 && n < budget);
      if (n >= budget)
         chk("idle_timeout", 32'(exp_beat.size() + exp_rsp.size()), 32'd0);
      @(posedge cpu_clk_g);
      #2;
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b1, 16'h0000, 4'd0,  32'h0000_000A, 4'h1,
                 16'h0000, 32'h0};
      tbl[1] = '{1'b0, 16'h0100, 4'd3,  32'h0, 4'h0,
                 16'h0103, 32'h0000_5B59};
      tbl[2] = '{1'b1, 16'hFFFE, 4'd3,  32'h1234_5678, 4'hF,
                 16'h0001, 32'h0};
      tbl[3] = '{1'b0, 16'hFFFF, 4'd1,  32'h0, 4'h0,
                 16'h0000, 32'h0000_5A5A};
      tbl[4] = '{1'b1, 16'h1234, 4'd15, 32'hDEAD_BEEF, 4'hC,
                 16'h1243, 32'h0};
      tbl[5] = '{1'b0, 16'h0010, 4'd0,  32'h0, 4'h0,
                 16'h0010, 32'h0000_5A4A};

      reset_button  = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.cmd_wdata = '0;
      bus.cmd_wstrb = '0;
      repeat (3) @(posedge cpu_clk_g);
      #1;
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_ext_en", 32'(bus.ext_en), 32'd0);
      chk("rst_ext_wea", 32'(bus.ext_wea), 32'd0);
      chk("rst_ext_addr", 32'(bus.ext_addr), 32'd0);
      chk("rst_ext_din", bus.ext_din, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_button = 1'b0;
      repeat (2) @(posedge cpu_clk_g);
      #2;

      // Single write: one beat, then ready again.
      issue(1'b1, 16'h0000, 4'd0, 32'h0000_000A, 4'h1);
      @(negedge cpu_clk_g);
      chk("sw_en", 32'(bus.ext_en), 32'd1);
      chk("sw_wea", 32'(bus.ext_wea), 32'h1);
      chk("sw_addr", 32'(bus.ext_addr), 32'h0);
      chk("sw_din", bus.ext_din, 32'hA);
      chk("sw_ready_low", 32'(bus.cmd_ready), 32'd0);
      @(negedge cpu_clk_g);
      chk("sw_en_off", 32'(bus.ext_en), 32'd0);
      chk("sw_ready_back", 32'(bus.cmd_ready), 32'd1);
      wait_idle(100);

      // Read burst: consecutive beats, rsp_valid two cycles after beat 0.
      issue(1'b0, 16'h0100, 4'd3, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge cpu_clk_g);
         chk("rb_en", 32'(bus.ext_en), 32'd1);
         chk("rb_addr", 32'(bus.ext_addr), 32'h100 + 32'(i));
         if (i == 1)
            chk("rb_rsp_early", 32'(bus.rsp_valid), 32'd0);
         if (i == 2)
            chk("rb_rsp_rise", 32'(bus.rsp_valid), 32'd1);
      end
      @(negedge cpu_clk_g);
      chk("rb_en_off", 32'(bus.ext_en), 32'd0);
      wait_idle(100);
      chk("rb_last_rsp", last_rsp, 32'h0000_5B59);

      // Backpressure: only 4 beats until the FIFO drains.
      rdy_mode = 0;
      repeat (2) @(posedge cpu_clk_g);
      #2;
      beat_cnt = 0;
      begin
         int p0;
         p0 = pops;
         issue(1'b0, 16'h0300, 4'd7, 32'h0, 4'h0);
         repeat (20) @(negedge cpu_clk_g);
         chk("bp_beats_held", 32'(beat_cnt), 32'd4);
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         rdy_mode = 1;
         wait_idle(200);
         chk("bp_pops", 32'(pops - p0), 32'd8);
         chk("bp_beats_all", 32'(beat_cnt), 32'd8);
      end

      // Write response presence depends on the build option.
      rdy_mode = 0;
      repeat (2) @(posedge cpu_clk_g);
      #2;
      issue(1'b1, 16'h0040, 4'd5, 32'h5555_AAAA, 4'h3);
      repeat (12) @(negedge cpu_clk_g);
`ifdef EXT_BUS_INITIATOR_WRACK_EN
      chk("wrack_valid", 32'(bus.rsp_valid), 32'd1);
      chk("wrack_data", bus.rsp_rdata, 32'h0000_0005);
`else
      chk("nowrack_valid", 32'(bus.rsp_valid), 32'd0);
`endif
      rdy_mode = 1;
      wait_idle(100);

      // Vector table.
      for (int v = 0; v < 6; v++) begin
         beat_cnt = 0;
         issue(tbl[v].wr, tbl[v].addr, tbl[v].len,
               tbl[v].wdata, tbl[v].wstrb);
         wait_idle(200);
         chk("tv_last_addr", 32'(last_addr), 32'(tbl[v].exp_last_addr));
         chk("tv_beats", 32'(beat_cnt), 32'(tbl[v].len) + 32'd1);
         if (!tbl[v].wr)
            chk("tv_last_rsp", last_rsp, tbl[v].exp_last_rsp);
      end

      // Randomized back-to-back commands with random rsp_ready.
      rdy_mode = 2;
      for (int k = 0; k < 40; k++) begin
         issue(1'($urandom_range(0, 1)), 16'($urandom),
               4'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(1, 15)));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 4)) @(posedge cpu_clk_g);
      end
      wait_idle(3000);
      rdy_mode = 1;
      repeat (2) @(posedge cpu_clk_g);
      #2;

      // Reset during beat 3 of a 16-beat read.
      begin
         int k = 0;
         int n = 0;
         issue(1'b0, 16'h0200, 4'd15, 32'h0, 4'h0);
         while (k < 3 && n < 50) begin
            @(negedge cpu_clk_g);
            n++;
            if (bus.ext_en)
               k++;
         end
         #2 reset_button = 1'b1;
         #1;
         chk("mr_ext_en", 32'(bus.ext_en), 32'd0);
         chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         exp_beat.delete();
         exp_rsp.delete();
         rd_issued = 0;
         pops = 0;
         @(negedge cpu_clk_g);
         #2 reset_button = 1'b0;
         beat_cnt = 0;
         repeat (20) @(negedge cpu_clk_g);
         chk("mr_no_beats", 32'(beat_cnt), 32'd0);
         chk("mr_busy", 32'(busy), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
